// File: rtl/universal_shift_register.sv
// Parametrised register with enable, parallel load and bidirectional serial shift.
// It tracks the shift count since the last load and pulses Word_Done once per completed word.
module universal_shift_register #(
    parameter int unsigned               WORD_LENGTH = 8,
    parameter logic [WORD_LENGTH-1:0]    RESET_VALUE = '0,
    localparam int unsigned              CNT_WIDTH   = $clog2(WORD_LENGTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic                   Serial_Input,
    input  logic [WORD_LENGTH-1:0] Data_Input,
    output logic [WORD_LENGTH-1:0] Data_Output,
    output logic                   Serial_Output_LSB,
    output logic                   Serial_Output_MSB,
    output logic [CNT_WIDTH-1:0]   Bit_Count,
    output logic                   Word_Done
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_SHL  = 2'b11
    } mode_e;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(WORD_LENGTH - 1);

    mode_e                  op;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic [WORD_LENGTH-1:0] shr_w, shl_w;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   done_q, done_d;

    assign op = mode_e'(mode);

    // A one-bit register has no neighbour to shift from, so both directions just take Serial_Input.
    if (WORD_LENGTH == 1) begin : g_single
        assign shr_w = Serial_Input;
        assign shl_w = Serial_Input;
    end else begin : g_multi
        assign shr_w = {Serial_Input, data_q[WORD_LENGTH-1:1]};
        assign shl_w = {data_q[WORD_LENGTH-2:0], Serial_Input};
    end

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (enable) begin
            unique case (op)
                MODE_HOLD: ;
                MODE_LOAD: begin
                    data_d = Data_Input;
                    cnt_d  = '0;
                end
                MODE_SHR, MODE_SHL: begin
                    data_d = (op == MODE_SHR) ? shr_w : shl_w;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= RESET_VALUE;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign Data_Output       = data_q;
    assign Serial_Output_LSB = data_q[0];
    assign Serial_Output_MSB = data_q[WORD_LENGTH-1];
    assign Bit_Count         = cnt_q;
    assign Word_Done         = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Table-driven bench for universal_shift_register (8-bit and 1-bit instances).
// Expected outputs are queued when each vector is driven and popped after the edge.
module tb_universal_shift_register;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          en8, sin8;
    logic [1:0]    mode8;
    logic [W-1:0]  din8, dout8;
    logic          lsb8, msb8, done8;
    logic [CW-1:0] cnt8;

    logic          en1, sin1;
    logic [1:0]    mode1;
    logic [0:0]    din1, dout1;
    logic          lsb1, msb1, done1;
    logic [0:0]    cnt1;

    universal_shift_register #(.WORD_LENGTH(W), .RESET_VALUE(8'h00)) dut8 (
        .clk(clk), .reset(rst_n), .enable(en8), .mode(mode8),
        .Serial_Input(sin8), .Data_Input(din8), .Data_Output(dout8),
        .Serial_Output_LSB(lsb8), .Serial_Output_MSB(msb8),
        .Bit_Count(cnt8), .Word_Done(done8)
    );

    universal_shift_register #(.WORD_LENGTH(1), .RESET_VALUE(1'b1)) dut1 (
        .clk(clk), .reset(rst_n), .enable(en1), .mode(mode1),
        .Serial_Input(sin1), .Data_Input(din1), .Data_Output(dout1),
        .Serial_Output_LSB(lsb1), .Serial_Output_MSB(msb1),
        .Bit_Count(cnt1), .Word_Done(done1)
    );

    typedef struct {
        logic         en;
        logic [1:0]   mode;
        logic         sin;
        logic [W-1:0] din;
        logic [W-1:0] data;
        logic [3:0]   cnt;
        logic         done;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic [3:0]   cnt;
        logic         done;
        int           idx;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(input logic en, input logic [1:0] mode, input logic sin,
                                input logic [W-1:0] din, input logic [W-1:0] data,
                                input logic [3:0] cnt, input logic done);
        vec_t v;
        v.en = en; v.mode = mode; v.sin = sin; v.din = din;
        v.data = data; v.cnt = cnt; v.done = done;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check8_pop();
        exp_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = exp_q.pop_front();
        check($sformatf("v%0d data", e.idx), 32'(dout8), 32'(e.data));
        check($sformatf("v%0d cnt", e.idx),  32'(cnt8),  32'(e.cnt));
        check($sformatf("v%0d done", e.idx), 32'(done8), 32'(e.done));
        check($sformatf("v%0d lsb", e.idx),  32'(lsb8),  32'(e.data[0]));
        check($sformatf("v%0d msb", e.idx),  32'(msb8),  32'(e.data[W-1]));
    endtask

    task automatic drive8(input vec_t v, input int idx);
        exp_t e;
        en8 = v.en; mode8 = v.mode; sin8 = v.sin; din8 = v.din;
        e.data = v.data; e.cnt = v.cnt; e.done = v.done; e.idx = idx;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check8_pop();
    endtask

    task automatic step1(input logic en, input logic [1:0] mode, input logic sin,
                         input logic din, input logic ed, input logic edone, input string name);
        en1 = en; mode1 = mode; sin1 = sin; din1 = din;
        @(posedge clk);
        #1;
        check({name, " data"}, 32'(dout1), 32'(ed));
        check({name, " cnt"},  32'(cnt1),  32'h0);
        check({name, " done"}, 32'(done1), 32'(edone));
        check({name, " lsb"},  32'(lsb1),  32'(ed));
        check({name, " msb"},  32'(msb1),  32'(ed));
    endtask

    initial begin
        vec_t v;
        logic [7:0] rx_bits;

        // Load 0xA5, then eight right shifts of 1s
        add(1, 2'b01, 0, 8'hA5, 8'hA5, 0, 0);
        add(1, 2'b10, 1, 8'h00, 8'hD2, 1, 0);
        add(1, 2'b10, 1, 8'h00, 8'hE9, 2, 0);
        add(1, 2'b10, 1, 8'h00, 8'hF4, 3, 0);
        add(1, 2'b10, 1, 8'h00, 8'hFA, 4, 0);
        add(1, 2'b10, 1, 8'h00, 8'hFD, 5, 0);
        add(1, 2'b10, 1, 8'h00, 8'hFE, 6, 0);
        add(1, 2'b10, 1, 8'h00, 8'hFF, 7, 0);
        add(1, 2'b10, 1, 8'h00, 8'hFF, 0, 1);
        add(1, 2'b00, 0, 8'h00, 8'hFF, 0, 0);
        // RX path: LSB-first bits 1,1,0,0,1,0,1,0 assemble 0x53, then a 9th shift
        add(1, 2'b01, 0, 8'h00, 8'h00, 0, 0);
        add(1, 2'b10, 1, 8'h00, 8'h80, 1, 0);
        add(1, 2'b10, 1, 8'h00, 8'hC0, 2, 0);
        add(1, 2'b10, 0, 8'h00, 8'h60, 3, 0);
        add(1, 2'b10, 0, 8'h00, 8'h30, 4, 0);
        add(1, 2'b10, 1, 8'h00, 8'h98, 5, 0);
        add(1, 2'b10, 0, 8'h00, 8'h4C, 6, 0);
        add(1, 2'b10, 1, 8'h00, 8'hA6, 7, 0);
        add(1, 2'b10, 0, 8'h00, 8'h53, 0, 1);
        add(1, 2'b10, 0, 8'h00, 8'h29, 1, 0);
        // Left shift from 0x81
        add(1, 2'b01, 0, 8'h81, 8'h81, 0, 0);
        add(1, 2'b11, 0, 8'h00, 8'h02, 1, 0);
        add(1, 2'b11, 0, 8'h00, 8'h04, 2, 0);
        add(1, 2'b11, 0, 8'h00, 8'h08, 3, 0);
        // Enable gating in the middle of a word
        add(1, 2'b01, 0, 8'h00, 8'h00, 0, 0);
        add(1, 2'b10, 1, 8'h00, 8'h80, 1, 0);
        add(1, 2'b10, 1, 8'h00, 8'hC0, 2, 0);
        add(1, 2'b10, 1, 8'h00, 8'hE0, 3, 0);
        add(1, 2'b10, 1, 8'h00, 8'hF0, 4, 0);
        add(0, 2'b10, 0, 8'h00, 8'hF0, 4, 0);
        add(0, 2'b10, 1, 8'h00, 8'hF0, 4, 0);
        add(0, 2'b10, 0, 8'h00, 8'hF0, 4, 0);
        add(0, 2'b10, 1, 8'h00, 8'hF0, 4, 0);
        add(0, 2'b10, 0, 8'h00, 8'hF0, 4, 0);
        add(1, 2'b10, 0, 8'h00, 8'h78, 5, 0);
        add(1, 2'b10, 0, 8'h00, 8'h3C, 6, 0);
        add(1, 2'b10, 0, 8'h00, 8'h1E, 7, 0);
        add(1, 2'b10, 0, 8'h00, 8'h0F, 0, 1);
        add(0, 2'b01, 0, 8'hAA, 8'h0F, 0, 0);
        // Load mid-word at count 6, then mixed directions share one count
        add(1, 2'b01, 0, 8'h00, 8'h00, 0, 0);
        add(1, 2'b11, 1, 8'h00, 8'h01, 1, 0);
        add(1, 2'b11, 1, 8'h00, 8'h03, 2, 0);
        add(1, 2'b11, 1, 8'h00, 8'h07, 3, 0);
        add(1, 2'b11, 1, 8'h00, 8'h0F, 4, 0);
        add(1, 2'b11, 1, 8'h00, 8'h1F, 5, 0);
        add(1, 2'b11, 1, 8'h00, 8'h3F, 6, 0);
        add(1, 2'b01, 0, 8'h3C, 8'h3C, 0, 0);
        add(1, 2'b10, 0, 8'h00, 8'h1E, 1, 0);
        add(1, 2'b11, 1, 8'h00, 8'h3D, 2, 0);

        rst_n = 1'b0;
        en8 = 1'b1; mode8 = 2'b10; sin8 = 1'b1; din8 = 8'hFF;
        en1 = 1'b1; mode1 = 2'b11; sin1 = 1'b0; din1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst8 data", 32'(dout8), 32'h00);
        check("rst8 cnt",  32'(cnt8),  32'h0);
        check("rst8 done", 32'(done8), 32'h0);
        check("rst1 data", 32'(dout1), 32'h1);
        check("rst1 done", 32'(done1), 32'h0);
        en8 = 1'b0; mode8 = 2'b00; en1 = 1'b0; mode1 = 2'b00;
        #2;
        rst_n = 1'b1;

        foreach (vecs[i]) drive8(vecs[i], i);

        // Asynchronous reset right after a completed word clears the pulse too
        v = vecs[10];
        drive8(v, 100);
        rx_bits = 8'b0101_0011;
        for (int unsigned i = 0; i < 8; i++) begin
            v.en = 1; v.mode = 2'b10; v.sin = rx_bits[i]; v.din = 8'h00;
            v.data = 8'(rx_bits << (7 - i)) & 8'(8'hFF << (7 - i));
            v.cnt = (i == 7) ? 4'd0 : 4'(i + 1);
            v.done = (i == 7);
            drive8(v, 101 + int'(i));
        end
        rst_n = 1'b0;
        #1;
        check("async rst after word data", 32'(dout8), 32'h00);
        check("async rst after word done", 32'(done8), 32'h0);
        #1;
        rst_n = 1'b1;

        // Asynchronous reset mid-shift at count 5
        v.en = 1; v.mode = 2'b01; v.sin = 0; v.din = 8'hC3;
        v.data = 8'hC3; v.cnt = 0; v.done = 0;
        drive8(v, 200);
        for (int unsigned i = 0; i < 5; i++) begin
            v.mode = 2'b11; v.sin = 1'b1;
            v.data = {v.data[6:0], 1'b1};
            v.cnt = 4'(i + 1);
            drive8(v, 201 + int'(i));
        end
        en8 = 1'b1; mode8 = 2'b11;
        rst_n = 1'b0;
        #1;
        check("async rst mid data", 32'(dout8), 32'h00);
        check("async rst mid cnt",  32'(cnt8),  32'h0);
        check("async rst mid done", 32'(done8), 32'h0);
        #1;
        rst_n = 1'b1;
        en8 = 1'b0;

        // Single-bit register: every shift completes a word
        step1(1, 2'b01, 0, 1'b0, 1'b0, 1'b0, "w1 load0");
        step1(1, 2'b10, 1, 1'b0, 1'b1, 1'b1, "w1 shr1");
        step1(1, 2'b11, 0, 1'b0, 1'b0, 1'b1, "w1 shl0");
        step1(1, 2'b10, 1, 1'b0, 1'b1, 1'b1, "w1 shr1b");
        step1(0, 2'b10, 0, 1'b0, 1'b1, 1'b0, "w1 disabled");
        step1(1, 2'b00, 0, 1'b0, 1'b1, 1'b0, "w1 hold");

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
